// File: rtl/mod_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : mod_apb_master
// Purpose  : Two-requester round-robin APB master with registered bus outputs.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef addrWidth
`define addrWidth 8
`endif
`ifndef dataWidth
`define dataWidth 32
`endif

module mod_apb_master #(
    parameter int ADDR_W   = `addrWidth,
    parameter int DATA_W   = `dataWidth,
    parameter int WAIT_CYC = 0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req0_write,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_write,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA
);

    localparam logic [3:0] WAIT_LAST = (WAIT_CYC > 15) ? 4'd15 : 4'(WAIT_CYC);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                rr_q, rr_d;
    logic                owner_q, owner_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                pwrite_q, pwrite_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                busy_q, busy_d;
    logic                rsp0_q, rsp0_d;
    logic                rsp1_q, rsp1_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic accept_win;
    logic any_valid;
    logic grant;
    logic accept;

    // rr_q names the requester preferred on contention.
    always_comb begin
        accept_win = (state_q == S_IDLE) ||
                     ((state_q == S_ACCESS) && (cnt_q == WAIT_LAST));
        any_valid  = req0_valid | req1_valid;
        grant      = (req0_valid && req1_valid) ? rr_q : req1_valid;
        accept     = accept_win & any_valid;
    end

    assign req0_ready = accept & ~grant;
    assign req1_ready = accept & grant;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_d     = rr_q;
        owner_d  = owner_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        rsp0_d   = 1'b0;
        rsp1_d   = 1'b0;
        rdata_d  = rdata_q;

        if (accept) begin
            rr_d     = ~grant;
            owner_d  = grant;
            paddr_d  = grant ? req1_addr  : req0_addr;
            pwdata_d = grant ? req1_wdata : req0_wdata;
            pwrite_d = grant ? req1_write : req0_write;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = 4'd0;
            end
            S_ACCESS: begin
                if (cnt_q != WAIT_LAST) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    rsp0_d  = ~owner_q;
                    rsp1_d  = owner_q;
                    rdata_d = pwrite_q ? '0 : PRDATA;
                    state_d = accept ? S_SETUP : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Bus strobes follow the next state so they come straight from flops.
        psel_d    = (state_d != S_IDLE);
        penable_d = (state_d == S_ACCESS);
        busy_d    = psel_d;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            rr_q      <= 1'b0;
            owner_q   <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            busy_q    <= 1'b0;
            rsp0_q    <= 1'b0;
            rsp1_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            owner_q   <= owner_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            busy_q    <= busy_d;
            rsp0_q    <= rsp0_d;
            rsp1_q    <= rsp1_d;
            rdata_q   <= rdata_d;
        end
    end

    assign PADDR      = paddr_q;
    assign PWDATA     = pwdata_q;
    assign PWRITE     = pwrite_q;
    assign PSELx      = psel_q;
    assign PENABLE    = penable_q;
    assign busy       = busy_q;
    assign rsp0_valid = rsp0_q;
    assign rsp1_valid = rsp1_q;
    assign rsp_rdata  = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mod_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_apb_master
// Purpose  : Scoreboard bench for mod_apb_master at WAIT_CYC=0 and WAIT_CYC=2.
// Revision : 1.0 - initial release
// ============================================================================

module tb_mod_apb_master;

    typedef struct {
        logic        write;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        int          req;
        longint      cyc;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int sel    = 0;

    logic [1:0]  rst_n = 2'b00;
    logic        v0 = 1'b0, v1 = 1'b0, w0 = 1'b0, w1 = 1'b0;
    logic [7:0]  a0 = 8'd0, a1 = 8'd0;
    logic [31:0] wd0 = 32'd0, wd1 = 32'd0;
    logic [1:0]  r0, r1, rv0, rv1, busy, psel, pen, pwr;
    logic [7:0]  paddr  [2];
    logic [31:0] pwdata [2];
    logic [31:0] rdata  [2];
    logic [31:0] prdata [2];

    // Slave read data is a fixed function of address; address 1 reads as 0x1.
    function automatic logic [31:0] slave_data(input logic [7:0] a);
        slave_data = {a ^ 8'h01, a ^ 8'h01, a ^ 8'h01, a};
    endfunction

    for (genvar d = 0; d < 2; d++) begin : g_dut
        mod_apb_master #(
            .ADDR_W  (8),
            .DATA_W  (32),
            .WAIT_CYC((d == 0) ? 0 : 2)
        ) u_dut (
            .PCLK       (clk),
            .PRESETn    (rst_n[d]),
            .req0_valid (v0),
            .req0_ready (r0[d]),
            .req0_addr  (a0),
            .req0_wdata (wd0),
            .req0_write (w0),
            .req1_valid (v1),
            .req1_ready (r1[d]),
            .req1_addr  (a1),
            .req1_wdata (wd1),
            .req1_write (w1),
            .rsp0_valid (rv0[d]),
            .rsp1_valid (rv1[d]),
            .rsp_rdata  (rdata[d]),
            .busy       (busy[d]),
            .PADDR      (paddr[d]),
            .PSELx      (psel[d]),
            .PENABLE    (pen[d]),
            .PWRITE     (pwr[d]),
            .PWDATA     (pwdata[d]),
            .PRDATA     (prdata[d])
        );
        assign prdata[d] = pen[d] ? slave_data(paddr[d]) : 32'hDEAD_BEEF;
    end

    // Reference model state: a transfer is a time window [sc, bu] of cycles.
    txn_t   sq0[$];
    txn_t   sq1[$];
    rsp_t   rspq[$];
    int     grant_log[$];
    longint cyc = 0;
    longint sc  = 0;
    longint bu  = -1;
    txn_t   cur;
    logic   rr  = 1'b0;
    bit     pend_acc = 1'b0;
    int     pend_g   = 0;
    txn_t   pend_t;
    bit     withdraw_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (WAIT=%0d cyc=%0d): got %0h expected %0h", name, sel * 2, cyc, act, exp);
        end
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.write = 1'($urandom_range(1));
        t.addr  = 8'($urandom);
        t.wdata = $urandom;
        return t;
    endfunction

    task automatic model_eval();
        bit   win, any, ps, pe;
        int   g;
        txn_t t0, t1;
        pend_acc = 1'b0;
        if (rst_n[sel]) begin
            win = (cyc >= bu);
            any = v0 || v1;
            g   = (v0 && v1) ? int'(rr) : int'(v1);
            check("ready0", 32'(r0[sel]), 32'(win && any && g == 0));
            check("ready1", 32'(r1[sel]), 32'(win && any && g == 1));
            ps = (cyc >= sc) && (cyc <= bu);
            pe = (cyc > sc) && (cyc <= bu);
            check("psel", 32'(psel[sel]), 32'(ps));
            check("penable", 32'(pen[sel]), 32'(pe));
            check("busy", 32'(busy[sel]), 32'(ps));
            if (ps) begin
                check("paddr", 32'(paddr[sel]), 32'(cur.addr));
                check("pwdata", pwdata[sel], cur.wdata);
                check("pwrite", 32'(pwr[sel]), 32'(cur.write));
            end
            if (win && any) begin
                t0.write = w0; t0.addr = a0; t0.wdata = wd0;
                t1.write = w1; t1.addr = a1; t1.wdata = wd1;
                pend_acc = 1'b1;
                pend_g   = g;
                pend_t   = (g == 1) ? t1 : t0;
            end
        end
    endtask

    task automatic model_commit();
        rsp_t   e;
        longint wc;
        wc = (sel == 0) ? 0 : 2;
        if (!rst_n[sel]) begin
            bu = -1;
            sc = 0;
            rr = 1'b0;
            rspq.delete();
        end else if (pend_acc) begin
            cur    = pend_t;
            sc     = cyc + 1;
            bu     = cyc + 2 + wc;
            rr     = (pend_g == 0);
            e.req  = pend_g;
            e.cyc  = cyc + 3 + wc;
            e.data = pend_t.write ? 32'd0 : slave_data(pend_t.addr);
            rspq.push_back(e);
            grant_log.push_back(pend_g);
        end
        cyc++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_eval();
            @(posedge clk);
            model_commit();
        end
    end

    // Scoreboard monitor: pops one expectation per response pulse.
    initial begin
        rsp_t e;
        logic vv;
        forever begin
            @(negedge clk);
            while (rspq.size() > 0 && rspq[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL rsp_missing (WAIT=%0d): req%0d response due at cyc %0d not seen", sel * 2, rspq[0].req, rspq[0].cyc);
                void'(rspq.pop_front());
            end
            for (int r = 0; r < 2; r++) begin
                vv = (r == 0) ? rv0[sel] : rv1[sel];
                if (vv) begin
                    if (rspq.size() == 0 || rspq[0].cyc != cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected (WAIT=%0d cyc=%0d): rsp%0d_valid high, no response expected", sel * 2, cyc, r);
                    end else begin
                        e = rspq.pop_front();
                        check("rsp_owner", 32'(r), 32'(e.req));
                        check("rsp_rdata", rdata[sel], e.data);
                    end
                end
            end
        end
    end

    task automatic present(input int r);
        if (r == 0) begin
            if (sq0.size() > 0 && !(withdraw_en && !v0 && $urandom_range(3) == 0)) begin
                v0 = 1'b1; w0 = sq0[0].write; a0 = sq0[0].addr; wd0 = sq0[0].wdata;
            end else begin
                v0 = 1'b0; w0 = 1'($urandom); a0 = 8'($urandom); wd0 = $urandom;
            end
        end else begin
            if (sq1.size() > 0 && !(withdraw_en && !v1 && $urandom_range(3) == 0)) begin
                v1 = 1'b1; w1 = sq1[0].write; a1 = sq1[0].addr; wd1 = sq1[0].wdata;
            end else begin
                v1 = 1'b0; w1 = 1'($urandom); a1 = 8'($urandom); wd1 = $urandom;
            end
        end
    endtask

    // Requester driver: holds a request until handshake, optionally withdrawing it.
    initial begin
        bit s0, s1, live;
        forever begin
            @(negedge clk);
            s0 = r0[sel];
            s1 = r1[sel];
            @(posedge clk);
            live = rst_n[sel];
            #1;
            if (v0 && ((s0 && live) || (withdraw_en && !s0 && $urandom_range(7) == 0)))
                void'(sq0.pop_front());
            if (v1 && ((s1 && live) || (withdraw_en && !s1 && $urandom_range(7) == 0)))
                void'(sq1.pop_front());
            present(0);
            present(1);
        end
    end

    function automatic bit is_idle();
        return sq0.size() == 0 && sq1.size() == 0 && rspq.size() == 0 &&
               !v0 && !v1 && cyc > bu + 1;
    endfunction

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (n < budget && !is_idle()) begin
            @(negedge clk);
            n++;
        end
        if (!is_idle()) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout (WAIT=%0d): not idle after %0d cycles", tag, sel * 2, budget);
            sq0.delete();
            sq1.delete();
        end
    endtask

    task automatic run_program(input int d);
        txn_t t;
        int   n;
        sel = d;

        @(negedge clk);
        check("rst_psel", 32'(psel[d]), 32'd0);
        check("rst_penable", 32'(pen[d]), 32'd0);
        check("rst_busy", 32'(busy[d]), 32'd0);
        check("rst_pwrite", 32'(pwr[d]), 32'd0);
        check("rst_rsp0", 32'(rv0[d]), 32'd0);
        check("rst_rsp1", 32'(rv1[d]), 32'd0);
        check("rst_paddr", 32'(paddr[d]), 32'd0);
        check("rst_pwdata", pwdata[d], 32'd0);
        check("rst_rdata", rdata[d], 32'd0);
        @(posedge clk);
        #3 rst_n[d] = 1'b1;

        t.write = 1'b1; t.addr = 8'd4; t.wdata = 32'd144;
        sq0.push_back(t);
        wait_idle(60, "write");

        t.write = 1'b0; t.addr = 8'd1; t.wdata = 32'd0;
        sq1.push_back(t);
        wait_idle(60, "read");

        // Contention starting from reset: strict alternation from req0.
        @(negedge clk);
        #2 rst_n[d] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sq0.push_back(rand_txn());
            sq1.push_back(rand_txn());
        end
        repeat (2) @(posedge clk);
        #3;
        grant_log.delete();
        rst_n[d] = 1'b1;
        wait_idle(120, "contention");
        check("grant_count", grant_log.size(), 32'd6);
        for (int i = 0; i < grant_log.size() && i < 6; i++)
            check("grant_order", grant_log[i], i % 2);

        // Asynchronous reset in the middle of ACCESS.
        t.write = 1'b1; t.addr = 8'h5A; t.wdata = 32'h1234_5678;
        sq0.push_back(t);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(cyc > sc && cyc <= bu) && n < 60);
        check("reached_access", 32'(pen[d]), 32'd1);
        t.write = 1'b0; t.addr = 8'h22; t.wdata = 32'd0;
        sq1.push_back(t);
        t.write = 1'b1; t.addr = 8'h33; t.wdata = 32'h0000_CAFE;
        sq0.push_back(t);
        #2 rst_n[d] = 1'b0;
        #1;
        check("async_psel", 32'(psel[d]), 32'd0);
        check("async_penable", 32'(pen[d]), 32'd0);
        check("async_busy", 32'(busy[d]), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n[d] = 1'b1;
        @(negedge clk);
        check("post_reset_ready0", 32'(r0[d]), 32'd1);
        check("post_reset_ready1", 32'(r1[d]), 32'd0);
        wait_idle(120, "reset_mid");

        withdraw_en = 1'b1;
        for (int i = 0; i < 25; i++) begin
            sq0.push_back(rand_txn());
            sq1.push_back(rand_txn());
        end
        wait_idle(3000, "random");
        withdraw_en = 1'b0;

        @(negedge clk);
        #2 rst_n[d] = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        run_program(0);
        run_program(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
